// File: rtl/acc_row_drain_pkg.sv
// Shared types for the accumulator read path: bank state encoding and element type.
package tpu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  typedef logic [DATA_W-1:0] acc_elem_t;

  function automatic logic bank_can_write(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

  function automatic logic bank_can_read(input bank_state_t s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/acc_row_drain_if.sv
// Element stream in from the systolic array and row stream out to the consumer.
interface acc_row_drain_if #(
  parameter int DATA_W = tpu_pkg::DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  // The drain block is the slave; the array/consumer side is the master.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/acc_row_drain_bank.sv
// One row bank: storage for ROW_LEN elements plus its EMPTY/FILLING/FULL/DRAINING state.
module acc_row_bank #(
  parameter int DATA_W  = tpu_pkg::DATA_W,
  parameter int ROW_LEN = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  output tpu_pkg::bank_state_t state,
  output logic [DATA_W-1:0]   rd_data,
  output logic                wr_last,
  output logic                rd_last
);

  import tpu_pkg::*;

  localparam int IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

  logic [DATA_W-1:0] mem [ROW_LEN];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // Writes and reads are mutually exclusive by state, so one branch per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= BANK_EMPTY;
      wr_idx <= '0;
      rd_idx <= '0;
      for (int i = 0; i < ROW_LEN; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && bank_can_write(state)) begin
      mem[wr_idx] <= wr_data;
      if (wr_idx == LAST_IDX) begin
        state  <= BANK_FULL;
        wr_idx <= '0;
      end else begin
        state  <= BANK_FILLING;
        wr_idx <= wr_idx + IDX_W'(1);
      end
    end else if (rd_en && bank_can_read(state)) begin
      if (rd_idx == LAST_IDX) begin
        state  <= BANK_EMPTY;
        rd_idx <= '0;
      end else begin
        state  <= BANK_DRAINING;
        rd_idx <= rd_idx + IDX_W'(1);
      end
    end
  end

  assign rd_data = mem[rd_idx];
  assign wr_last = (wr_idx == LAST_IDX);
  assign rd_last = (rd_idx == LAST_IDX);

endmodule

// File: rtl/acc_row_drain.sv
// Double-banked row capture: one bank fills from the array while the other drains.
module acc_row_drain #(
  parameter int DATA_W  = tpu_pkg::DATA_W,
  parameter int ROW_LEN = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  acc_row_drain_if.slave             bus,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [CNT_W-1:0]           rows_done
);

  import tpu_pkg::*;

  bank_state_t       bank_state [2];
  logic [DATA_W-1:0] bank_rd_data [2];
  logic              bank_wr_last [2];
  logic              bank_rd_last [2];
  logic              bank_wr_en [2];
  logic              bank_rd_en [2];

  logic wr_bank;
  logic rd_bank;
  logic wr_fire;
  logic rd_fire;
  logic wr_row_done;
  logic rd_row_done;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    acc_row_bank #(
      .DATA_W (DATA_W),
      .ROW_LEN(ROW_LEN)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (bank_wr_en[b]),
      .wr_data(bus.in_data),
      .rd_en  (bank_rd_en[b]),
      .state  (bank_state[b]),
      .rd_data(bank_rd_data[b]),
      .wr_last(bank_wr_last[b]),
      .rd_last(bank_rd_last[b])
    );
  end

  // Handshakes depend only on registered bank state; a freed bank accepts next cycle.
  assign bus.in_ready  = bank_can_write(bank_state[wr_bank]);
  assign bus.out_valid = bank_can_read(bank_state[rd_bank]);
  assign bus.out_data  = bank_rd_data[rd_bank];
  assign bus.out_last  = bus.out_valid && bank_rd_last[rd_bank];

  assign wr_fire     = bus.in_valid && bus.in_ready;
  assign rd_fire     = bus.out_valid && bus.out_ready;
  assign wr_row_done = wr_fire && bank_wr_last[wr_bank];
  assign rd_row_done = rd_fire && bank_rd_last[rd_bank];

  assign bank_wr_en[0] = wr_fire && (wr_bank == 1'b0);
  assign bank_wr_en[1] = wr_fire && (wr_bank == 1'b1);
  assign bank_rd_en[0] = rd_fire && (rd_bank == 1'b0);
  assign bank_rd_en[1] = rd_fire && (rd_bank == 1'b1);

  assign full  = bank_can_read(bank_state[0]) && bank_can_read(bank_state[1]);
  assign empty = (bank_state[0] == BANK_EMPTY) && (bank_state[1] == BANK_EMPTY);

  // Bank selects alternate per row, so rows leave in the order they arrived.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      overflow  <= 1'b0;
      rows_done <= '0;
    end else begin
      if (wr_row_done) begin
        wr_bank <= ~wr_bank;
      end
      if (rd_row_done) begin
        rd_bank   <= ~rd_bank;
        rows_done <= rows_done + CNT_W'(1);
      end
      if (bus.in_valid && !bus.in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_row_drain.sv
// Randomized bench for acc_row_drain against a queue-based model of row capture and drain.
module tb_acc_row_drain;

  localparam int DW = 8;
  localparam int RL = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [CW-1:0] rows_done;

  always #5 clk = ~clk;

  acc_row_drain_if #(.DATA_W(DW)) bus();

  acc_row_drain #(
    .DATA_W (DW),
    .ROW_LEN(RL),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .rows_done(rows_done)
  );

  int checks = 0;
  int errors = 0;

  // Model: elements of the partial row, elements of completed undrained rows, and counters.
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  int            pending = 0;
  int            rd_pos = 0;
  bit            m_ovf = 1'b0;
  int            m_rows = 0;
  bit            started = 1'b0;
  logic [8:0]    log_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkLog(input string name, input logic [8:0] exp_q[$]);
    checkOutput({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checkOutput($sformatf("%s_beat%0d", name, i), {23'd0, log_q[i]}, {23'd0, exp_q[i]});
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin : model
    bit acc;
    bit drop;
    bit beat;
    if (reset) begin
      wq.delete();
      rq.delete();
      pending = 0;
      rd_pos  = 0;
      m_ovf   = 1'b0;
      m_rows  = 0;
      started = 1'b1;
    end else if (started) begin
      acc  = bus.in_valid && (pending < 2);
      drop = bus.in_valid && !(pending < 2);
      beat = (pending > 0) && bus.out_ready;
      if (beat) begin
        void'(rq.pop_front());
        rd_pos++;
        if (rd_pos == RL) begin
          rd_pos = 0;
          pending--;
          m_rows++;
        end
      end
      if (acc) begin
        wq.push_back(bus.in_data);
        if (wq.size() == RL) begin
          foreach (wq[i]) rq.push_back(wq[i]);
          wq.delete();
          pending++;
        end
      end
      if (drop) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("in_ready", bus.in_ready, pending < 2);
      checkOutput("out_valid", bus.out_valid, pending > 0);
      checkOutput("full", full, pending == 2);
      checkOutput("empty", empty, (pending == 0) && (wq.size() == 0));
      checkOutput("overflow", overflow, m_ovf);
      checkOutput("rows_done", rows_done, m_rows & 32'hFFFF);
      if (pending > 0) begin
        checkOutput("out_data", bus.out_data, rq[0]);
        checkOutput("out_last", bus.out_last, rd_pos == RL - 1);
      end
      if (bus.out_valid && bus.out_ready) log_q.push_back({bus.out_last, bus.out_data});
    end
  end

  initial begin
    logic [8:0] exp_q[$];
    int         stalls;
    logic       r;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_out_last", bus.out_last, 0);

    $display("[TB] idle after reset");
    repeat (5) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("idle_in_ready", bus.in_ready, 1);
    checkOutput("idle_empty", empty, 1);
    checkOutput("idle_out_valid", bus.out_valid, 0);
    checkOutput("idle_rows_done", rows_done, 0);
    checkOutput("idle_overflow", overflow, 0);
    checkOutput("idle_full", full, 0);

    $display("[TB] zero-valued row");
    log_q.delete();
    applyStimulus(1'b1, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h11, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    exp_q = '{9'h000, 9'h111};
    checkLog("zero_row", exp_q);
    checkOutput("zero_rows_done", rows_done, 1);

    $display("[TB] both banks full, then overflow");
    log_q.delete();
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0);
    checkOutput("full_full", full, 1);
    checkOutput("full_in_ready", bus.in_ready, 0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    checkOutput("full_overflow", overflow, 1);
    repeat (6) applyStimulus(1'b0, '0, 1'b1);
    exp_q = '{9'h001, 9'h102, 9'h003, 9'h104};
    checkLog("full_drain", exp_q);
    checkOutput("full_rows_done", rows_done, 3);

    $display("[TB] continuous stream");
    log_q.delete();
    stalls = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (!bus.in_ready) stalls++;
      applyStimulus(1'b1, 8'h30 + 8'(i), 1'b1);
      exp_q.push_back({i[0], 8'h30 + 8'(i)});
    end
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("cont_stalls", stalls, 0);
    checkLog("cont", exp_q);
    checkOutput("cont_rows_done", rows_done, 11);

    $display("[TB] random traffic with toggling out_ready");
    r = 1'b0;
    for (int i = 0; i < 200; i++) begin
      r = ~r;
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), r);
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (8) applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] reset discards partial row");
    log_q.delete();
    applyStimulus(1'b1, 8'hAA, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    reset = 1'b0;
    checkOutput("mid_rst_empty", empty, 1);
    checkOutput("mid_rst_rows_done", rows_done, 0);
    checkOutput("mid_rst_overflow", overflow, 0);
    applyStimulus(1'b1, 8'h10, 1'b1);
    applyStimulus(1'b1, 8'h20, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    exp_q = '{9'h010, 9'h120};
    checkLog("mid_rst", exp_q);
    checkOutput("mid_rst_rows", rows_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
